timer_apb_master: RTL and testbench

- Bus initiator that drives the timer register bank's APB-style slave port (sel/write/enable/one-hot selected_reg/wdata, ready/rdata).
- Accepts single read/write commands from a local controller (CPU shim or test sequencer) and decodes the byte address to a one-hot register select.
- Runs one SETUP+ACCESS transfer per command, with a wait-state timeout, and returns a response.

---
 rtl/timer_pkg.sv | 27 ++
 rtl/timer_apb_master_if.sv | 35 +++
 rtl/timer_addr_decode.sv | 25 ++
 rtl/timer_apb_master_checker.sv | 27 ++
 rtl/timer_apb_master.sv | 154 +++++++++++++++
 tb/tb_timer_apb_master.sv | 206 ++++++++++++++++++++
 6 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer register bank and its APB-style initiator:
// register addresses, one-hot indices, initiator state encoding, bus idle values.
package timer_pkg;

   // Byte addresses of the timer registers
   localparam int unsigned TDR_ADDR = 0;
   localparam int unsigned TCR_ADDR = 1;
   localparam int unsigned TSR_ADDR = 2;

   // Bit positions of each register in the one-hot select
   localparam int unsigned TDR_INDEX = 0;
   localparam int unsigned TCR_INDEX = 1;
   localparam int unsigned TSR_INDEX = 2;

   // Bus values driven whenever no transfer is in progress
   localparam logic BUS_SEL_IDLE    = 1'b0;
   localparam logic BUS_ENABLE_IDLE = 1'b0;

   // Initiator transfer states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } apbm_state_e;

endpackage : timer_pkg

// File: rtl/timer_apb_master_if.sv
// APB-style bus between the timer initiator and the timer register bank.
interface timer_apb_master_if #(
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 3
) ();

   logic                apbm_sel;
   logic                apbm_write;
   logic                apbm_enable;
   logic [NUM_REGS-1:0] apbm_selected_reg;
   logic [DATA_W-1:0]   apbm_wdata;
   logic                apbm_ready;
   logic [DATA_W-1:0]   apbm_rdata;

   modport master (
      output apbm_sel,
      output apbm_write,
      output apbm_enable,
      output apbm_selected_reg,
      output apbm_wdata,
      input  apbm_ready,
      input  apbm_rdata
   );

   modport slave (
      input  apbm_sel,
      input  apbm_write,
      input  apbm_enable,
      input  apbm_selected_reg,
      input  apbm_wdata,
      output apbm_ready,
      output apbm_rdata
   );

endinterface : timer_apb_master_if

// File: rtl/timer_addr_decode.sv
// Byte address to one-hot timer register select. Out-of-range addresses give
// an all-zero select and addr_valid low. Shared with the slave-side blocks.
module timer_addr_decode #(
   parameter int ADDR_W   = 8,
   parameter int NUM_REGS = 3
) (
   input  logic [ADDR_W-1:0]   addr,
   output logic [NUM_REGS-1:0] onehot,
   output logic                addr_valid
);

   logic [NUM_REGS-1:0] onehot_s;

   // One select bit per register; at most one can match a given address
   always_comb begin
      onehot_s = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         onehot_s[i] = (addr == ADDR_W'(i));
      end
   end

   assign onehot     = onehot_s;
   assign addr_valid = |onehot_s;

endmodule : timer_addr_decode

// File: rtl/timer_apb_master_checker.sv
// Protocol invariants of the initiator bus side.
module timer_apb_master_checker #(
   parameter int NUM_REGS = 3
) (
   input logic                apbm_clk,
   input logic                apbm_reset_n,
   input logic                sel,
   input logic                enable,
   input logic [NUM_REGS-1:0] selected_reg,
   input logic                rsp_valid
);

   // Access phase is only legal inside a selected transfer
   a_enable_needs_sel: assert property (@(posedge apbm_clk) disable iff (!apbm_reset_n)
      enable |-> sel);

   // Register select is one-hot during a transfer and clear otherwise
   a_sel_onehot: assert property (@(posedge apbm_clk) disable iff (!apbm_reset_n)
      sel |-> $onehot(selected_reg));
   a_idle_no_select: assert property (@(posedge apbm_clk) disable iff (!apbm_reset_n)
      !sel |-> (selected_reg == '0));

   // A response never overlaps bus activity
   a_rsp_not_on_bus: assert property (@(posedge apbm_clk) disable iff (!apbm_reset_n)
      rsp_valid |-> !sel);

endmodule : timer_apb_master_checker

// File: rtl/timer_apb_master.sv
// Single-command APB-style initiator for the timer register bank.
// IDLE accepts a command, SETUP drives select for one cycle, ACCESS waits for
// ready (bounded by TIMEOUT wait states), RESP pulses the response for a cycle.
module timer_apb_master
   import timer_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 8,
   parameter int NUM_REGS = 3,
   parameter int TIMEOUT  = 15
) (
   input  logic              apbm_clk,
   input  logic              apbm_reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   timer_apb_master_if.master apbm
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   apbm_state_e         state_r;
   logic [CNT_W-1:0]    wait_cnt_r;
   logic                sel_r;
   logic                enable_r;
   logic                write_r;
   logic [NUM_REGS-1:0] selected_reg_r;
   logic [DATA_W-1:0]   wdata_r;
   logic                rsp_valid_r;
   logic [DATA_W-1:0]   rsp_rdata_r;
   logic                rsp_err_r;

   logic [NUM_REGS-1:0] dec_onehot_s;
   logic                dec_valid_s;

   timer_addr_decode #(
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
   ) u_addr_decode (
      .addr       (cmd_addr),
      .onehot     (dec_onehot_s),
      .addr_valid (dec_valid_s)
   );

   // Transfer sequencer; every bus and response output is a register here so
   // slave ready never reaches the bus combinationally
   always_ff @(posedge apbm_clk or negedge apbm_reset_n) begin
      if (!apbm_reset_n) begin
         state_r        <= ST_IDLE;
         wait_cnt_r     <= '0;
         sel_r          <= 1'b0;
         enable_r       <= 1'b0;
         write_r        <= 1'b0;
         selected_reg_r <= '0;
         wdata_r        <= '0;
         rsp_valid_r    <= 1'b0;
         rsp_rdata_r    <= '0;
         rsp_err_r      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               rsp_valid_r <= 1'b0;
               if (cmd_valid) begin
                  if (dec_valid_s) begin
                     // Bus signals go live at the start of SETUP
                     state_r        <= ST_SETUP;
                     sel_r          <= 1'b1;
                     enable_r       <= 1'b0;
                     write_r        <= cmd_write;
                     wdata_r        <= cmd_wdata;
                     selected_reg_r <= dec_onehot_s;
                  end else begin
                     // Unmapped address: answer at once, bus untouched
                     state_r     <= ST_RESP;
                     rsp_valid_r <= 1'b1;
                     rsp_err_r   <= 1'b1;
                     rsp_rdata_r <= '0;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_SETUP: begin
               state_r    <= ST_ACCESS;
               enable_r   <= 1'b1;
               wait_cnt_r <= '0;
            end
            ST_ACCESS: begin
               if (apbm.apbm_ready) begin
                  // Ready wins even on the last tolerated wait state
                  state_r        <= ST_RESP;
                  sel_r          <= BUS_SEL_IDLE;
                  enable_r       <= BUS_ENABLE_IDLE;
                  selected_reg_r <= '0;
                  rsp_valid_r    <= 1'b1;
                  rsp_err_r      <= 1'b0;
                  rsp_rdata_r    <= write_r ? '0 : apbm.apbm_rdata;
               end else if (wait_cnt_r == CNT_W'(TIMEOUT)) begin
                  state_r        <= ST_RESP;
                  sel_r          <= BUS_SEL_IDLE;
                  enable_r       <= BUS_ENABLE_IDLE;
                  selected_reg_r <= '0;
                  rsp_valid_r    <= 1'b1;
                  rsp_err_r      <= 1'b1;
                  rsp_rdata_r    <= '0;
               end else begin
                  wait_cnt_r <= wait_cnt_r + CNT_W'(1);
               end
            end
            ST_RESP: begin
               state_r     <= ST_IDLE;
               rsp_valid_r <= 1'b0;
            end
            default: begin
               state_r        <= ST_IDLE;
               sel_r          <= BUS_SEL_IDLE;
               enable_r       <= BUS_ENABLE_IDLE;
               selected_reg_r <= '0;
               rsp_valid_r    <= 1'b0;
            end
         endcase
      end
   end

   // Ready is decoded from state but forced low while reset is held
   assign cmd_ready = (state_r == ST_IDLE) && apbm_reset_n;

   assign rsp_valid = rsp_valid_r;
   assign rsp_rdata = rsp_rdata_r;
   assign rsp_err   = rsp_err_r;

   assign apbm.apbm_sel          = sel_r;
   assign apbm.apbm_write        = write_r;
   assign apbm.apbm_enable       = enable_r;
   assign apbm.apbm_selected_reg = selected_reg_r;
   assign apbm.apbm_wdata        = wdata_r;

   timer_apb_master_checker #(
      .NUM_REGS (NUM_REGS)
   ) u_checker (
      .apbm_clk     (apbm_clk),
      .apbm_reset_n (apbm_reset_n),
      .sel          (sel_r),
      .enable       (enable_r),
      .selected_reg (selected_reg_r),
      .rsp_valid    (rsp_valid_r)
   );

endmodule : timer_apb_master

// File: tb/tb_timer_apb_master.sv
// Directed bench for timer_apb_master: zero-wait write, read with waits,
// timeout, ready on the last wait state, bad address, reset mid-transfer.
module tb_timer_apb_master;

   logic       apbm_clk;
   logic       apbm_reset_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_write;
   logic [7:0] cmd_addr;
   logic [7:0] cmd_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_err;

   int errors = 0;
   int checks = 0;

   timer_apb_master_if #(.DATA_W(8), .NUM_REGS(3)) bus ();

   timer_apb_master #(
      .DATA_W   (8),
      .ADDR_W   (8),
      .NUM_REGS (3),
      .TIMEOUT  (15)
   ) dut (
      .apbm_clk     (apbm_clk),
      .apbm_reset_n (apbm_reset_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_write    (cmd_write),
      .cmd_addr     (cmd_addr),
      .cmd_wdata    (cmd_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .apbm         (bus.master)
   );

   initial apbm_clk = 1'b0;
   always #5 apbm_clk = ~apbm_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge apbm_clk);
      #1;
   endtask

   // Bus snapshot check: sel, enable, write, selected_reg, wdata
   task automatic check_bus(input string tag, input logic s, input logic e, input logic w,
                            input logic [2:0] r, input logic [7:0] d);
      check({tag, ".sel"}, 32'(bus.apbm_sel), 32'(s));
      check({tag, ".enable"}, 32'(bus.apbm_enable), 32'(e));
      check({tag, ".write"}, 32'(bus.apbm_write), 32'(w));
      check({tag, ".selreg"}, 32'(bus.apbm_selected_reg), 32'(r));
      check({tag, ".wdata"}, 32'(bus.apbm_wdata), 32'(d));
   endtask

   task automatic check_rsp(input string tag, input logic v, input logic [7:0] d, input logic e);
      check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(v));
      check({tag, ".rsp_rdata"}, 32'(rsp_rdata), 32'(d));
      check({tag, ".rsp_err"}, 32'(rsp_err), 32'(e));
   endtask

   initial begin
      apbm_reset_n    = 1'b0;
      cmd_valid       = 1'b0;
      cmd_write       = 1'b0;
      cmd_addr        = 8'h00;
      cmd_wdata       = 8'h00;
      bus.apbm_ready  = 1'b0;
      bus.apbm_rdata  = 8'h00;

      // Reset state
      #12;
      check("reset.cmd_ready", 32'(cmd_ready), 32'd0);
      check_bus("reset", 1'b0, 1'b0, 1'b0, 3'b000, 8'h00);
      check_rsp("reset", 1'b0, 8'h00, 1'b0);
      tick();
      apbm_reset_n = 1'b1;
      #1;
      check("idle.cmd_ready", 32'(cmd_ready), 32'd1);

      // Write, zero wait states: addr 0, data A5
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h00; cmd_wdata = 8'hA5;
      bus.apbm_ready = 1'b1;
      tick();                                   // T+1 SETUP
      cmd_valid = 1'b0;
      check_bus("wr.setup", 1'b1, 1'b0, 1'b1, 3'b001, 8'hA5);
      check("wr.setup.cmd_ready", 32'(cmd_ready), 32'd0);
      tick();                                   // T+2 ACCESS
      check_bus("wr.access", 1'b1, 1'b1, 1'b1, 3'b001, 8'hA5);
      check("wr.access.rsp_valid", 32'(rsp_valid), 32'd0);
      tick();                                   // T+3 RESP
      check_rsp("wr.resp", 1'b1, 8'h00, 1'b0);
      check_bus("wr.resp", 1'b0, 1'b0, 1'b1, 3'b000, 8'hA5);
      tick();                                   // back in IDLE
      check("wr.after.rsp_valid", 32'(rsp_valid), 32'd0);
      check("wr.after.cmd_ready", 32'(cmd_ready), 32'd1);

      // Read with 3 wait states: addr 1, slave returns 3C
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h01; cmd_wdata = 8'h00;
      bus.apbm_ready = 1'b0; bus.apbm_rdata = 8'h3C;
      tick();                                   // T+1 SETUP
      cmd_valid = 1'b0;
      check_bus("rd.setup", 1'b1, 1'b0, 1'b0, 3'b010, 8'h00);
      for (int i = 0; i < 3; i++) begin
         tick();                                // T+2..T+4 ACCESS, not ready
         check_bus("rd.wait", 1'b1, 1'b1, 1'b0, 3'b010, 8'h00);
         check("rd.wait.rsp_valid", 32'(rsp_valid), 32'd0);
      end
      tick();                                   // T+5 ACCESS, ready now
      bus.apbm_ready = 1'b1;
      check_bus("rd.last", 1'b1, 1'b1, 1'b0, 3'b010, 8'h00);
      tick();                                   // T+6 RESP
      check_rsp("rd.resp", 1'b1, 8'h3C, 1'b0);
      tick();
      check("rd.hold.rsp_rdata", 32'(rsp_rdata), 32'h3C);
      check("rd.hold.rsp_valid", 32'(rsp_valid), 32'd0);

      // Timeout: addr 2, ready never rises -> 16 ACCESS cycles then abort
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h02;
      bus.apbm_ready = 1'b0; bus.apbm_rdata = 8'h99;
      tick();                                   // SETUP
      cmd_valid = 1'b0;
      check_bus("to.setup", 1'b1, 1'b0, 1'b0, 3'b100, 8'h00);
      for (int i = 0; i < 16; i++) begin
         tick();
         check("to.access.enable", 32'(bus.apbm_enable), 32'd1);
         check("to.access.rsp_valid", 32'(rsp_valid), 32'd0);
      end
      tick();                                   // RESP after 16th ACCESS
      check_rsp("to.resp", 1'b1, 8'h00, 1'b1);
      check_bus("to.resp", 1'b0, 1'b0, 1'b0, 3'b000, 8'h00);
      tick();

      // Ready on the 16th ACCESS cycle: success
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h00;
      bus.apbm_ready = 1'b0; bus.apbm_rdata = 8'h77;
      tick();                                   // SETUP
      cmd_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tick();
         check("lim.access.rsp_valid", 32'(rsp_valid), 32'd0);
      end
      bus.apbm_ready = 1'b1;                    // during 16th ACCESS
      check("lim.access16.enable", 32'(bus.apbm_enable), 32'd1);
      tick();
      check_rsp("lim.resp", 1'b1, 8'h77, 1'b0);
      tick();

      // Bad address: immediate error, no bus activity, write/wdata hold
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h05; cmd_wdata = 8'hEE;
      tick();                                   // T+1
      cmd_valid = 1'b0;
      check_rsp("bad.resp", 1'b1, 8'h00, 1'b1);
      check_bus("bad.bus", 1'b0, 1'b0, 1'b0, 3'b000, 8'h00);
      tick();
      check("bad.after.rsp_valid", 32'(rsp_valid), 32'd0);
      check("bad.after.sel", 32'(bus.apbm_sel), 32'd0);

      // Reset asserted mid-ACCESS
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h01;
      bus.apbm_ready = 1'b0;
      tick();                                   // SETUP
      cmd_valid = 1'b0;
      tick();                                   // ACCESS
      check("rst.pre.enable", 32'(bus.apbm_enable), 32'd1);
      #2;
      apbm_reset_n = 1'b0;
      #1;                                       // still before next edge
      check_bus("rst.async", 1'b0, 1'b0, 1'b0, 3'b000, 8'h00);
      check("rst.async.cmd_ready", 32'(cmd_ready), 32'd0);
      tick();
      tick();
      check("rst.held.rsp_valid", 32'(rsp_valid), 32'd0);
      apbm_reset_n = 1'b1;
      #1;
      check("rst.rel.cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst.rel.rsp_valid", 32'(rsp_valid), 32'd0);

      // Normal write after reset: addr 0, data 5A
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h00; cmd_wdata = 8'h5A;
      bus.apbm_ready = 1'b1;
      tick();
      cmd_valid = 1'b0;
      check_bus("post.setup", 1'b1, 1'b0, 1'b1, 3'b001, 8'h5A);
      tick();
      check_bus("post.access", 1'b1, 1'b1, 1'b1, 3'b001, 8'h5A);
      tick();
      check_rsp("post.resp", 1'b1, 8'h00, 1'b0);
      tick();
      check("post.idle.cmd_ready", 32'(cmd_ready), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_timer_apb_master
